// File: rtl/myproject_fixed_pkg.sv
// Shared fixed-point helpers for the CNN MAC lanes: rounding/overflow mode
// constants, product width and saturation bounds.
package myproject_fixed_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;
  localparam int OVF_WRAP    = 0;
  localparam int OVF_SAT     = 1;

  // One extra bit so an unsigned din1 can be carried as a signed operand.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/myproject_rsat.sv
// Combinational round / arithmetic-shift / saturate of a full-width signed
// product down to the output fixed-point format, with an overflow flag.
module myproject_rsat
  import myproject_fixed_pkg::*;
#(
  parameter int PW       = 30,
  parameter int DW       = 16,
  parameter int SHIFT    = 12,
  parameter int ROUND    = RND_HALF_UP,
  parameter int SATURATE = OVF_SAT
) (
  input  logic signed [PW-1:0] p,
  output logic        [DW-1:0] dout,
  output logic                 ovf
);

  localparam int RW = PW + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (ROUND == RND_HALF_UP && SHIFT > 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [63:0] MAXV = sat_max(DW);
  localparam logic signed [63:0] MINV = sat_min(DW);

  logic signed [RW-1:0] r;
  logic signed [RW-1:0] s;
  logic signed [63:0]   s64;

  // The extra bit on r keeps the half-LSB addition from wrapping.
  always_comb begin
    r   = {p[PW-1], p} + RND;
    s   = r >>> SHIFT;
    s64 = 64'(s);
    ovf = (s64 > MAXV) || (s64 < MINV);
    if (SATURATE == OVF_SAT && ovf) begin
      dout = (s64 < 0) ? DW'(MINV) : DW'(MAXV);
    end else begin
      dout = s[DW-1:0];
    end
  end

endmodule

// File: rtl/myproject_mul_rsat_pipe.sv
// Pipelined fixed-point multiplier for a MAC lane: signed activation times
// signed/unsigned weight, then round/shift/saturate, 1..4 stages with ce.
module myproject_mul_rsat_pipe
  import myproject_fixed_pkg::*;
#(
  parameter int din0_WIDTH  = 16,
  parameter int din1_WIDTH  = 13,
  parameter int dout_WIDTH  = 16,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 12,
  parameter int ROUND       = RND_HALF_UP,
  parameter int SATURATE    = OVF_SAT,
  parameter int NUM_STAGE   = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  clr,
  output logic                  out_vld,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  ovf_sticky
);

  localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);

  logic signed [din1_WIDTH:0]   b_ext;
  logic signed [din0_WIDTH-1:0] a_s;
  logic signed [din1_WIDTH:0]   b_s;
  logic                         v_s;
  logic signed [PW-1:0]         p_c;
  logic signed [PW-1:0]         p1;
  logic signed [PW-1:0]         p2;
  logic                         v1;
  logic                         v2;
  logic [dout_WIDTH-1:0]        dout_c;
  logic                         ovf_c;

  always_comb begin
    b_ext = (DIN1_SIGNED != 0) ? {din1[din1_WIDTH-1], din1} : {1'b0, din1};
  end

  generate
    if (NUM_STAGE >= 3) begin : g_in_reg
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          v_s <= 1'b0;
        end else if (ce) begin
          v_s <= in_vld;
          a_s <= din0;
          b_s <= b_ext;
        end
      end
    end else begin : g_in_pass
      always_comb begin
        v_s = in_vld;
        a_s = din0;
        b_s = b_ext;
      end
    end
  endgenerate

  // Single multiply so synthesis can map it onto one DSP slice.
  always_comb begin
    p_c = PW'(a_s) * PW'(b_s);
  end

  generate
    if (NUM_STAGE >= 2) begin : g_prod_reg
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          v1 <= 1'b0;
        end else if (ce) begin
          v1 <= v_s;
          p1 <= p_c;
        end
      end
    end else begin : g_prod_pass
      always_comb begin
        v1 = v_s;
        p1 = p_c;
      end
    end

    if (NUM_STAGE >= 4) begin : g_preg
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          v2 <= 1'b0;
        end else if (ce) begin
          v2 <= v1;
          p2 <= p1;
        end
      end
    end else begin : g_preg_pass
      always_comb begin
        v2 = v1;
        p2 = p1;
      end
    end
  endgenerate

  myproject_rsat #(
    .PW      (PW),
    .DW      (dout_WIDTH),
    .SHIFT   (SHIFT),
    .ROUND   (ROUND),
    .SATURATE(SATURATE)
  ) u_rsat (
    .p   (p2),
    .dout(dout_c),
    .ovf (ovf_c)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_vld <= 1'b0;
      dout    <= '0;
      ovf     <= 1'b0;
    end else if (ce) begin
      out_vld <= v2;
      dout    <= dout_c;
      ovf     <= v2 & ovf_c;
    end
  end

  // clr wins over a same-cycle set and still acts while the pipe is stalled.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      ovf_sticky <= 1'b0;
    end else if (ce && out_vld && ovf) begin
      ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_myproject_mul_rsat_pipe.sv
// Scoreboard bench: several parameterisations share one stimulus stream and
// are compared against an integer-arithmetic reference of the fixed-point rules.
module tb_myproject_mul_rsat_pipe;

  localparam int NCFG = 9;
  localparam int CFG_NS   [NCFG] = '{3, 1, 2, 4, 3, 3, 1, 4, 3};
  localparam int CFG_SHIFT[NCFG] = '{12, 12, 12, 12, 12, 12, 0, 28, 12};
  localparam int CFG_ROUND[NCFG] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
  localparam int CFG_SAT  [NCFG] = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
  localparam int CFG_SGN  [NCFG] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};

  typedef struct {
    logic [15:0] dout;
    bit          ovf;
    int          due;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ce;
  logic        in_vld;
  logic        clr;
  logic [15:0] din0;
  logic [12:0] din1;

  logic        out_vld_a [NCFG];
  logic [15:0] dout_a    [NCFG];
  logic        ovf_a     [NCFG];
  logic        sticky_a  [NCFG];
  int          qsz       [NCFG];

  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Plain integer evaluation of multiply, round-half-up, floor shift, clamp.
  function automatic exp_t refModel(input logic [15:0] d0, input logic [12:0] d1,
                                    input int shift, input int round,
                                    input int sat, input int sgn);
    exp_t   e;
    longint a;
    longint b;
    longint p;
    longint s;
    a = longint'($signed(d0));
    b = (sgn != 0) ? longint'($signed(d1)) : longint'(d1);
    p = a * b;
    if (round != 0 && shift > 0) p = p + (longint'(1) << (shift - 1));
    s = p >>> shift;
    e.ovf = (s > 32767) || (s < -32768);
    if (sat != 0 && s > 32767) s = 32767;
    if (sat != 0 && s < -32768) s = -32768;
    e.dout = s[15:0];
    e.due  = 0;
    return e;
  endfunction

  generate
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      exp_t        q[$];
      exp_t        e;
      int          advCnt = 0;
      bit          adv = 0;
      bit          rstFlag = 0;
      bit          pVld = 0;
      bit          pOvf = 0;
      logic [15:0] pDout = '0;
      bit          expSticky = 0;

      myproject_mul_rsat_pipe #(
        .din0_WIDTH (16),
        .din1_WIDTH (13),
        .dout_WIDTH (16),
        .DIN1_SIGNED(CFG_SGN[g]),
        .SHIFT      (CFG_SHIFT[g]),
        .ROUND      (CFG_ROUND[g]),
        .SATURATE   (CFG_SAT[g]),
        .NUM_STAGE  (CFG_NS[g])
      ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ce        (ce),
        .in_vld    (in_vld),
        .din0      (din0),
        .din1      (din1),
        .clr       (clr),
        .out_vld   (out_vld_a[g]),
        .dout      (dout_a[g]),
        .ovf       (ovf_a[g]),
        .ovf_sticky(sticky_a[g])
      );

      // Stimulus side: every accepted sample pushes its expected result and
      // the advance count at which it must first be presented.
      always @(posedge ap_clk) begin
        if (ap_rst) begin
          q.delete();
          adv       = 0;
          rstFlag   = 1;
          pVld      = 0;
          pOvf      = 0;
          pDout     = '0;
          expSticky = 0;
        end else begin
          rstFlag = 0;
          if (clr) expSticky = 0;
          else if (ce && pVld && pOvf) expSticky = 1;
          if (ce) begin
            advCnt++;
            adv = 1;
            if (in_vld) begin
              e = refModel(din0, din1, CFG_SHIFT[g], CFG_ROUND[g], CFG_SAT[g], CFG_SGN[g]);
              e.due = advCnt + CFG_NS[g] - 1;
              q.push_back(e);
            end
          end else begin
            adv = 0;
          end
        end
      end

      // Monitor side: pops whenever the DUT presents a valid output.
      always @(negedge ap_clk) begin
        if (rstFlag) begin
          check($sformatf("cfg%0d reset out_vld", g), 64'(out_vld_a[g]), 64'd0);
          check($sformatf("cfg%0d reset dout", g), 64'(dout_a[g]), 64'd0);
          check($sformatf("cfg%0d reset ovf", g), 64'(ovf_a[g]), 64'd0);
        end else if (adv) begin
          if (out_vld_a[g]) begin
            if (q.size() == 0) begin
              check($sformatf("cfg%0d spurious out_vld", g), 64'(out_vld_a[g]), 64'd0);
              pVld = 0;
              pOvf = 0;
            end else begin
              e = q.pop_front();
              check($sformatf("cfg%0d dout", g), 64'(dout_a[g]), 64'(e.dout));
              check($sformatf("cfg%0d ovf", g), 64'(ovf_a[g]), 64'(e.ovf));
              check($sformatf("cfg%0d latency", g), 64'(advCnt), 64'(e.due));
              pVld  = 1;
              pOvf  = e.ovf;
              pDout = e.dout;
            end
          end else begin
            check($sformatf("cfg%0d ovf while invalid", g), 64'(ovf_a[g]), 64'd0);
            if (q.size() > 0 && q[0].due <= advCnt) begin
              void'(q.pop_front());
              check($sformatf("cfg%0d missing out_vld", g), 64'(out_vld_a[g]), 64'd1);
            end
            pVld = 0;
            pOvf = 0;
          end
        end else begin
          check($sformatf("cfg%0d stall out_vld", g), 64'(out_vld_a[g]), 64'(pVld));
          if (pVld) begin
            check($sformatf("cfg%0d stall dout", g), 64'(dout_a[g]), 64'(pDout));
            check($sformatf("cfg%0d stall ovf", g), 64'(ovf_a[g]), 64'(pOvf));
          end
        end
        check($sformatf("cfg%0d ovf_sticky", g), 64'(sticky_a[g]), 64'(expSticky));
        qsz[g] = q.size();
      end
    end
  endgenerate

  task automatic applyStimulus(input logic [15:0] d0, input logic [12:0] d1, input logic v);
    din0   = d0;
    din1   = d1;
    in_vld = v;
    @(negedge ap_clk);
  endtask

  // One sample then idle until it reaches the output of the 3-stage configs.
  task automatic runDirected(input logic [15:0] d0, input logic [12:0] d1);
    applyStimulus(d0, d1, 1'b1);
    applyStimulus(16'd0, 13'd0, 1'b0);
    applyStimulus(16'd0, 13'd0, 1'b0);
  endtask

  task automatic checkOutput(input int idx, input logic [15:0] expDout,
                             input logic expOvf, input string name);
    check({name, " out_vld"}, 64'(out_vld_a[idx]), 64'd1);
    check({name, " dout"}, 64'(dout_a[idx]), 64'(expDout));
    check({name, " ovf"}, 64'(ovf_a[idx]), 64'(expOvf));
  endtask

  initial begin
    ap_rst = 1'b1;
    ce     = 1'b0;
    in_vld = 1'b0;
    clr    = 1'b0;
    din0   = '0;
    din1   = '0;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    ce     = 1'b1;

    runDirected(16'd4096, 13'd2048);
    checkOutput(0, 16'd2048, 1'b0, "unity");

    runDirected(16'd3, 13'd2048);
    checkOutput(0, 16'd2, 1'b0, "round half up");
    checkOutput(4, 16'd1, 1'b0, "truncate");

    runDirected(16'd32767, 13'd8191);
    checkOutput(0, 16'h7FFF, 1'b1, "sat positive");
    checkOutput(8, 16'hFFF6, 1'b1, "wrap positive");
    applyStimulus(16'd0, 13'd0, 1'b0);
    check("sticky after sat", 64'(sticky_a[0]), 64'd1);
    clr = 1'b1;
    applyStimulus(16'd0, 13'd0, 1'b0);
    clr = 1'b0;
    check("sticky after clr", 64'(sticky_a[0]), 64'd0);

    runDirected(16'h8000, 13'd8191);
    checkOutput(0, 16'h8000, 1'b1, "sat negative");

    runDirected(16'd4096, 13'h1FFF);
    checkOutput(0, 16'd8191, 1'b0, "din1 unsigned");
    checkOutput(5, 16'hFFFF, 1'b0, "din1 signed");

    // Five-sample stream with a four-cycle ce drop in the middle.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        ce = 1'b0;
        repeat (4) applyStimulus(16'($urandom), 13'($urandom), 1'b1);
        ce = 1'b1;
      end
      applyStimulus(16'($urandom), 13'($urandom), 1'b1);
    end
    repeat (6) applyStimulus(16'd0, 13'd0, 1'b0);

    // Two samples in flight, then a one-cycle reset drops them.
    applyStimulus(16'd1234, 13'd321, 1'b1);
    applyStimulus(16'd4321, 13'd123, 1'b1);
    ap_rst = 1'b1;
    applyStimulus(16'd999, 13'd99, 1'b1);
    ap_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'd0, 13'd0, 1'b0);
      check("post-reset out_vld", 64'(out_vld_a[0]), 64'd0);
    end

    for (int i = 0; i < 800; i++) begin
      logic [15:0] a;
      logic [12:0] b;
      case ($urandom_range(0, 5))
        0:       a = 16'h7FFF;
        1:       a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b = 13'h1FFF;
        1:       b = 13'h1000;
        default: b = 13'($urandom);
      endcase
      ap_rst = ($urandom_range(0, 199) == 0);
      ce     = ($urandom_range(0, 99) < 85);
      clr    = ($urandom_range(0, 49) == 0);
      applyStimulus(a, b, 1'($urandom_range(0, 99) < 70));
    end

    ap_rst = 1'b0;
    clr    = 1'b0;
    ce     = 1'b1;
    repeat (8) applyStimulus(16'd0, 13'd0, 1'b0);
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("cfg%0d outstanding samples", i), 64'(qsz[i]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/myproject_mul_rsat_pipe.md
# myproject_mul_rsat_pipe

Pipelined, parametrised fixed-point multiplier: next generation of the combinational `mul_<a>s_<b>ns` cores used by the pruned CNN layers. It adds a selectable din1 signedness, a configurable pipeline depth with clock-enable and valid tracking, and post-multiply shift, round and saturate to the layer's output fixed-point format. It sits between the weight/activation fetch and the accumulator in each MAC lane.

## Interface
- din0_WIDTH, 16: activation width, always signed.
- din1_WIDTH, 13: weight width.
- dout_WIDTH, 16: result width, signed.
- DIN1_SIGNED, 0: 0 = din1 is unsigned (zero-extended), 1 = din1 is two's complement.
- SHIFT, 12: arithmetic right shift applied to the full product, range 0..din0_WIDTH+din1_WIDTH-1.
- ROUND, 1: 1 = round half up before the shift (ignored when SHIFT=0), 0 = truncate toward -inf.
- SATURATE, 1: 1 = clamp to the dout range, 0 = wrap (keep the low dout_WIDTH bits).
- NUM_STAGE, 3: latency in cycles, legal values 1..4.
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- ce  in  1  pipeline advance enable.
- in_vld  in  1  din0/din1 valid this cycle.
- din0  in  din0_WIDTH  multiplicand.
- din1  in  din1_WIDTH  multiplier.
- out_vld  out  1  dout/ovf valid.
- dout  out  dout_WIDTH  shifted, rounded, saturated product.
- ovf  out  1  result exceeded the dout range (qualified by out_vld).
- ovf_sticky  out  1  OR of all qualified ovf since reset or clr.
- clr  in  1  clears ovf_sticky; takes priority over a same-cycle set.

## Operation
- Full product P has width PW = din0_WIDTH+din1_WIDTH+1. It is the signed din0 times din1, with din1 sign- or zero-extended per DIN1_SIGNED. The product is exact.
- Rounding: R = P + 2^(SHIFT-1) when ROUND=1 and SHIFT>0, otherwise R = P. R is computed at PW+1 bits so it cannot overflow.
- Shift: S = R >>> SHIFT (arithmetic).
- Range check: ovf = 1 when S > 2^(dout_WIDTH-1)-1 or S < -2^(dout_WIDTH-1). ovf reflects this check in both SATURATE modes.
- Output: dout = the clamped value when SATURATE=1, otherwise S[dout_WIDTH-1:0].
- Valid bit travels alongside the data through every stage. Data registers load regardless of in_vld, so invalid slots carry don't-care data but out_vld=0. ovf is forced to 0 when out_vld=0.
- ovf_sticky sets on a cycle where ce & out_vld & ovf. clr clears it.

## Timing
- Stage mapping:
  - NUM_STAGE=1: output register only.
  - NUM_STAGE=2: adds a product register.
  - NUM_STAGE=3: adds an input register.
  - NUM_STAGE=4: adds a second product register (DSP P-reg retiming).
- With ce held high, a sample accepted at cycle t appears at t+NUM_STAGE. Throughput is one sample per cycle with no backpressure.
- ce=0 freezes every register, including the valid bits, out_vld, dout and ovf. ovf_sticky is not set while ce=0. clr still acts while ce=0.
- Reset values: out_vld=0, dout=0, ovf=0, ovf_sticky=0, all internal valid bits 0.
- Reset beats ce. Reset in mid-stream drops every in-flight sample; none of them emerges after reset is released.
- Back-to-back samples, including alternating valid/invalid ones, must keep their order and alignment.

## Structure
- Shared package myproject_fixed_pkg holds:
  - the rounding-mode and overflow-mode constants;
  - a function returning PW from the two input widths;
  - the min/max saturation bound functions for a given width.
- One sub-module, myproject_rsat, is natural: combinational round/shift/saturate with ovf output, reused by the accumulator output stage.
- The multiply is written as a single `*` so that synthesis infers a DSP.

## Test plan
All cases use the default parameters unless stated.
- Unity scaling: din0=4096, din1=2048, in_vld=1 -> 3 cycles later out_vld=1, dout=2048, ovf=0.
- Rounding: din0=3, din1=2048 -> dout=2. Same input with ROUND=0 -> dout=1.
- Saturation:
  - din0=32767, din1=8191 -> dout=32767, ovf=1, ovf_sticky=1.
  - din0=-32768, din1=8191 -> dout=-32768, ovf=1.
  - With SATURATE=0, the first case gives dout = low 16 bits of 65526 = -10, ovf=1.
- Signedness:
  - din0=4096, din1=13'h1FFF with DIN1_SIGNED=1 -> dout=-1.
  - Same input with DIN1_SIGNED=0 -> dout=8191.
- Stall and reset:
  - Stream 5 samples, drop ce for 4 cycles in mid-stream -> outputs are held and the outputs keep their order with no loss or duplication.
  - Assert ap_rst for 1 cycle with 2 samples in flight -> out_vld stays 0 until new input arrives.
  - clr pulse -> ovf_sticky=0 next cycle.
- Sweep NUM_STAGE 1..4 with random vectors against a reference model -> bit-exact dout/ovf at latency NUM_STAGE.
